div_unit: RTL and testbench



---
 rtl/div_unit.sv | 170 +++++++++++++++++
 tb/tb_div_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One operation at a time over a start/busy/done handshake.
// The operation takes 34 cycles from the start cycle to the done cycle.
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined, a divide by
// zero or a signed overflow found at acceptance jumps straight to DONE.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  div_control,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        Z
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] divisor_q;
    logic [31:0] dividendRaw_q;
    logic        isRem_q;
    logic        negQ_q;
    logic        negR_q;
    logic        divZero_q;
    logic        overflow_q;
    logic [31:0] result_q;
    logic        z_q;
    logic        busy_q;
    logic        done_q;

    logic        isSigned;
    logic [31:0] absA;
    logic [31:0] absB;
    logic        acceptDivZero;
    logic        acceptOverflow;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        noBorrow;
    logic [31:0] remNext;
    logic [31:0] quoNext;
    logic [31:0] qSigned;
    logic [31:0] rSigned;
    logic [31:0] fixResult;

    // RISC-V mandated results for divide-by-zero and signed overflow
    function automatic logic [31:0] specialValue(input logic isRem, input logic divZero,
                                                 input logic [31:0] dividend);
        if (divZero)
            specialValue = isRem ? dividend : 32'hFFFF_FFFF;
        else
            specialValue = isRem ? 32'h0000_0000 : 32'h8000_0000;
    endfunction

    // Decode the live operands: magnitudes and special cases for acceptance
    always_comb begin
        isSigned       = ~div_control[0];
        absA           = (isSigned && A[31]) ? (32'd0 - A) : A;
        absB           = (isSigned && B[31]) ? (32'd0 - B) : B;
        acceptDivZero  = (B == 32'd0);
        acceptOverflow = isSigned && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    end

    // One restoring step: the 33-bit partial remainder is the old remainder shifted
    // left with the next dividend bit, and bit 32 of the difference is the borrow
    always_comb begin
        shifted  = {1'b0, rem_q, quo_q[31]};
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {1'b0, divisor_q};
        noBorrow = ~diff[32];
        remNext  = noBorrow ? diff[31:0] : shifted[31:0];
        quoNext  = {quo_q[30:0], noBorrow};
    end

    // Sign fix-up and selection; the special cases override the iterated value
    always_comb begin
        qSigned = negQ_q ? (32'd0 - quo_q) : quo_q;
        rSigned = negR_q ? (32'd0 - rem_q) : rem_q;
        if (divZero_q || overflow_q)
            fixResult = specialValue(isRem_q, divZero_q, dividendRaw_q);
        else
            fixResult = isRem_q ? rSigned : qSigned;
    end

    // Control FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 5'd0;
            rem_q         <= 32'd0;
            quo_q         <= 32'd0;
            divisor_q     <= 32'd0;
            dividendRaw_q <= 32'd0;
            isRem_q       <= 1'b0;
            negQ_q        <= 1'b0;
            negR_q        <= 1'b0;
            divZero_q     <= 1'b0;
            overflow_q    <= 1'b0;
            result_q      <= 32'd0;
            z_q           <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        cnt_q         <= 5'd31;
                        rem_q         <= 32'd0;
                        quo_q         <= absA;
                        divisor_q     <= absB;
                        dividendRaw_q <= A;
                        isRem_q       <= div_control[1];
                        negQ_q        <= isSigned & (A[31] ^ B[31]);
                        negR_q        <= isSigned & A[31];
                        divZero_q     <= acceptDivZero;
                        overflow_q    <= acceptOverflow;
                        busy_q        <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
                        if (acceptDivZero || acceptOverflow) begin
                            state_q  <= DONE;
                            result_q <= specialValue(div_control[1], acceptDivZero, A);
                            z_q      <= (specialValue(div_control[1], acceptDivZero, A) == 32'd0);
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            done_q  <= 1'b0;
                        end
`else
                        state_q <= CALC;
                        done_q  <= 1'b0;
`endif
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                CALC: begin
                    rem_q <= remNext;
                    quo_q <= quoNext;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0)
                        state_q <= SIGN;
                end
                SIGN: begin
                    state_q  <= DONE;
                    result_q <= fixResult;
                    z_q      <= (fixResult == 32'd0);
                    done_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign Z      = z_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector bench for div_unit (honours DIV_EARLY_OUT_EN).
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  div_control;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        Z;

    int checks = 0;
    int errors = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 34;
`endif
    localparam int NORMAL_LAT = 34;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] expResult;
        logic        expZ;
        bit          special;
    } vec_t;

    vec_t vectors[16];

    div_unit dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .A(A),
        .B(B),
        .div_control(div_control),
        .result(result),
        .busy(busy),
        .done(done),
        .Z(Z)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Waits for done on falling edges; lat counts falling edges after the accept edge
    task automatic waitDone(output int lat, output bit busySeen);
        lat = -1;
        busySeen = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) busySeen = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    // Issues one start pulse, then scrambles the operands while the unit works
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op, output int lat, output bit busySeen);
        @(negedge clk);
        A = a;
        B = b;
        div_control = op;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = ~a;
        B = $urandom;
        div_control = ~op;
        waitDone(lat, busySeen);
    endtask

    initial begin
        int  lat;
        bit  busySeen;
        int  doneCount;

        vectors[0]  = '{"divu_100_7",  32'd100,        32'd7,          2'b01, 32'd14,         1'b0, 1'b0};
        vectors[1]  = '{"remu_100_7",  32'd100,        32'd7,          2'b11, 32'd2,          1'b0, 1'b0};
        vectors[2]  = '{"div_m7_2",    32'hFFFF_FFF9,  32'd2,          2'b00, 32'hFFFF_FFFD,  1'b0, 1'b0};
        vectors[3]  = '{"rem_m7_2",    32'hFFFF_FFF9,  32'd2,          2'b10, 32'hFFFF_FFFF,  1'b0, 1'b0};
        vectors[4]  = '{"divu_5_0",    32'd5,          32'd0,          2'b01, 32'hFFFF_FFFF,  1'b0, 1'b1};
        vectors[5]  = '{"rem_5_0",     32'd5,          32'd0,          2'b10, 32'd5,          1'b0, 1'b1};
        vectors[6]  = '{"div_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  2'b00, 32'h8000_0000,  1'b0, 1'b1};
        vectors[7]  = '{"rem_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  2'b10, 32'd0,          1'b1, 1'b1};
        vectors[8]  = '{"div_0_5",     32'd0,          32'd5,          2'b00, 32'd0,          1'b1, 1'b0};
        vectors[9]  = '{"divu_max_10", 32'hFFFF_FFFF,  32'd10,         2'b01, 32'h1999_9999,  1'b0, 1'b0};
        vectors[10] = '{"remu_max_10", 32'hFFFF_FFFF,  32'd10,         2'b11, 32'd5,          1'b0, 1'b0};
        vectors[11] = '{"div_7_m2",    32'd7,          32'hFFFF_FFFE,  2'b00, 32'hFFFF_FFFD,  1'b0, 1'b0};
        vectors[12] = '{"rem_7_m2",    32'd7,          32'hFFFF_FFFE,  2'b10, 32'd1,          1'b0, 1'b0};
        vectors[13] = '{"div_min_1",   32'h8000_0000,  32'd1,          2'b00, 32'h8000_0000,  1'b0, 1'b0};
        vectors[14] = '{"div_m20_m6",  32'hFFFF_FFEC,  32'hFFFF_FFFA,  2'b00, 32'd3,          1'b0, 1'b0};
        vectors[15] = '{"rem_m20_m6",  32'hFFFF_FFEC,  32'hFFFF_FFFA,  2'b10, 32'hFFFF_FFFE,  1'b0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        A = 32'd0;
        B = 32'd0;
        div_control = 2'b00;
        repeat (3) @(negedge clk);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_Z", {31'd0, Z}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].op, lat, busySeen);
            checkOutput({vectors[i].name, "_latency"}, lat,
                        vectors[i].special ? SPECIAL_LAT : NORMAL_LAT);
            checkOutput({vectors[i].name, "_result"}, result, vectors[i].expResult);
            checkOutput({vectors[i].name, "_Z"}, {31'd0, Z}, {31'd0, vectors[i].expZ});
            checkOutput({vectors[i].name, "_busy"}, {31'd0, busySeen}, 32'd1);
            @(negedge clk);
            checkOutput({vectors[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
            checkOutput({vectors[i].name, "_idle_busy"}, {31'd0, busy}, 32'd0);
            checkOutput({vectors[i].name, "_hold"}, result, vectors[i].expResult);
        end

        // Start held high: operands present only at each accept edge matter
        @(negedge clk);
        A = 32'd100;
        B = 32'd7;
        div_control = 2'b01;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            lat = -1;
            busySeen = 1'b1;
            for (int n = 1; n <= 60; n++) begin
                @(negedge clk);
                if (busy !== 1'b1) busySeen = 1'b0;
                if (done === 1'b1) begin
                    lat = n;
                    break;
                end
                A = $urandom;
                B = $urandom | 32'd1;
                div_control = 2'($urandom);
            end
            checkOutput(k == 0 ? "b2b_first_latency" : "b2b_second_latency", lat, NORMAL_LAT);
            checkOutput(k == 0 ? "b2b_first_result" : "b2b_second_result", result,
                        k == 0 ? 32'd14 : 32'd22);
            checkOutput(k == 0 ? "b2b_first_busy" : "b2b_second_busy", {31'd0, busySeen}, 32'd1);
            if (k == 0) begin
                A = 32'd200;
                B = 32'd9;
                div_control = 2'b01;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("b2b_done_drop", {31'd0, done}, 32'd0);
        checkOutput("b2b_busy_drop", {31'd0, busy}, 32'd0);

        // Reset in the middle of CALC discards the operation
        @(negedge clk);
        A = 32'd1000;
        B = 32'd7;
        div_control = 2'b01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, done}, 32'd0);
        checkOutput("midreset_result", result, 32'd0);
        checkOutput("midreset_Z", {31'd0, Z}, 32'd1);
        doneCount = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) doneCount++;
        end
        checkOutput("midreset_no_done", doneCount, 32'd0);

        applyStimulus(32'd9, 32'd3, 2'b01, lat, busySeen);
        checkOutput("after_reset_latency", lat, NORMAL_LAT);
        checkOutput("after_reset_result", result, 32'd3);
        checkOutput("after_reset_Z", {31'd0, Z}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
